uart_tx_fifo: RTL and testbench

- Memory-mapped UART transmitter for the RISC-V SoC I/O space.
- Sits on the same I/O bus as the GPIO block: en/write_enable/addr/data_in/data_out.
- Adds a parametrised TX FIFO, a runtime-programmable baud divisor and a configurable data width.
- Standard LSB-first framing; drives uart_txd directly.

---
 rtl/uart_tx_fifo_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets decoded from addr[3:0]
//   - STATUS register bit positions
//   - transmit FSM state encoding
package uart_tx_fifo_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h2;
    localparam logic [3:0] UART_STATUS = 4'h3;
    localparam logic [3:0] UART_DIV    = 4'h4;
    localparam logic [3:0] UART_CTRL   = 4'h5;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_OVERFLOW = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO, shared by the UART TX path
// and intended for a future RX path.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, din        write request and data (dropped when full)
//   pop              read request (ignored when empty)
//   dout             head-of-queue word, valid whenever empty=0
//   full, empty      occupancy flags
//   count            number of stored words, $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Memory-mapped UART transmitter with TX FIFO and programmable baud divisor.
// Optional feature macro: UART_PARITY_EN (adds a parity bit and a CTRL
// register at offset 0x5 whose bit0 selects odd parity).
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   en              block select
//   write_enable    byte-lane strobes, bit [2] qualifies a write
//   addr            I/O address, only addr[3:0] decoded
//   data_in         write data
//   data_out        read data, high impedance when not selected/unmapped
//   uart_txd        serial output, idles high
//   irq             high while FIFO is empty and the transmitter is idle
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 104,
    parameter int DIV_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  write_enable,
    input  logic [23:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        uart_txd,
    output logic        irq
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] BITS_TOP = BCW'(DATA_BITS - 1);

    logic [3:0]           offset;
    logic                 wr_cycle;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_WIDTH-1:0] div_wdata;
    logic                 overflow;
    logic                 busy;

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic [BCW-1:0]       bit_cnt, bit_cnt_n;
    logic [DIV_WIDTH-1:0] baud_cnt, baud_n;
    logic [DIV_WIDTH-1:0] latched_div, latched_n;
    logic                 tick;
    logic                 frame_load;

    logic [31:0]          rdata;
    logic                 mapped;
    logic                 unused_ok;

`ifdef UART_PARITY_EN
    logic                 ctrl_odd;
    logic                 par_bit, par_n;
`endif

    assign offset    = addr[3:0];
    assign wr_cycle  = en & write_enable[2];
    assign fifo_push = wr_cycle & (offset == UART_TXDATA);
    assign unused_ok = ^{addr[23:4], write_enable[1:0], data_in[31:DIV_WIDTH], fifo_count};

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (data_in[DATA_BITS-1:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // With parity enabled the divisor's top bit is reserved and reads as 0.
    always_comb begin
        div_wdata = data_in[DIV_WIDTH-1:0];
`ifdef UART_PARITY_EN
        div_wdata[DIV_WIDTH-1] = 1'b0;
`endif
    end

    // Configuration and sticky overflow. Divisors below 2 are clamped so
    // every bit lasts at least two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor  <= DIV_WIDTH'(DEFAULT_DIV);
            overflow <= 1'b0;
`ifdef UART_PARITY_EN
            ctrl_odd <= 1'b0;
`endif
        end else begin
            if (wr_cycle && offset == UART_DIV) begin
                divisor <= (div_wdata < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_wdata;
            end
            if (wr_cycle && offset == UART_STATUS) begin
                overflow <= 1'b0;
            end else if (fifo_push && fifo_full) begin
                overflow <= 1'b1;
            end
`ifdef UART_PARITY_EN
            if (wr_cycle && offset == UART_CTRL) begin
                ctrl_odd <= data_in[0];
            end
`endif
        end
    end

    assign tick = (baud_cnt == '0);

    // Transmit state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            baud_cnt    <= '0;
            latched_div <= DIV_WIDTH'(DEFAULT_DIV);
`ifdef UART_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            shift_reg   <= shift_n;
            bit_cnt     <= bit_cnt_n;
            baud_cnt    <= baud_n;
            latched_div <= latched_n;
`ifdef UART_PARITY_EN
            par_bit     <= par_n;
`endif
        end
    end

    // Next-state logic. A frame load (from IDLE or at the end of STOP)
    // pops the FIFO and latches the divisor so later divisor writes only
    // affect the following frame.
    always_comb begin
        state_n    = state;
        shift_n    = shift_reg;
        bit_cnt_n  = bit_cnt;
        baud_n     = baud_cnt;
        latched_n  = latched_div;
        fifo_pop   = 1'b0;
        frame_load = 1'b0;
`ifdef UART_PARITY_EN
        par_n      = par_bit;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    frame_load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = BITS_TOP;
                    baud_n    = latched_div - 1'b1;
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_n = shift_reg >> 1;
                    baud_n  = latched_div - 1'b1;
                    if (bit_cnt == '0) begin
`ifdef UART_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt - 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_n = ST_STOP;
                    baud_n  = latched_div - 1'b1;
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        frame_load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (frame_load) begin
            fifo_pop  = 1'b1;
            shift_n   = fifo_dout;
            latched_n = divisor;
            baud_n    = divisor - 1'b1;
            state_n   = ST_START;
`ifdef UART_PARITY_EN
            par_n     = (^fifo_dout) ^ ctrl_odd;
`endif
        end
    end

    // Line level is decoded from registered state, so an asynchronous
    // reset forces it high immediately.
    always_comb begin
        case (state)
            ST_START: uart_txd = 1'b0;
            ST_DATA:  uart_txd = shift_reg[0];
`ifdef UART_PARITY_EN
            ST_PARITY: uart_txd = par_bit;
`endif
            default:  uart_txd = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE) | ~fifo_empty;
    assign irq  = fifo_empty & (state == ST_IDLE);

    // Read mux; STATUS reflects registered flags so a read coinciding with
    // an overflowing push returns the pre-update value.
    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (offset)
            UART_TXDATA: rdata = '0;
            UART_STATUS: begin
                rdata[STAT_BUSY]     = busy;
                rdata[STAT_EMPTY]    = fifo_empty;
                rdata[STAT_FULL]     = fifo_full;
                rdata[STAT_OVERFLOW] = overflow;
            end
            UART_DIV: rdata[DIV_WIDTH-1:0] = divisor;
`ifdef UART_PARITY_EN
            UART_CTRL: rdata[0] = ctrl_odd;
`endif
            default: mapped = 1'b0;
        endcase
    end

    assign data_out = (en && mapped) ? rdata : 32'hz;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Scoreboard bench for uart_tx_fifo (default build, 8 data bits, depth 16).
// Stimulus pushes expected frames {byte, divisor, back-to-back} into a queue;
// a monitor decodes uart_txd on falling clock edges and compares every
// sample of each frame against the expected waveform.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam logic [3:0] OFF_TXDATA = 4'h2;
    localparam logic [3:0] OFF_STATUS = 4'h3;
    localparam logic [3:0] OFF_DIV    = 4'h4;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         contig;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  write_enable = 3'b000;
    logic [23:0] addr = '0;
    logic [31:0] data_in = '0;
    wire  [31:0] data_out;
    wire         uart_txd;
    wire         irq;

    int     total = 0;
    int     bad = 0;
    bit     mon_en = 1'b0;
    int     idle_cycles = 0;
    frame_t sb[$];

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .write_enable (write_enable),
        .addr         (addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .uart_txd     (uart_txd),
        .irq          (irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end 1ns after a rising edge.
    task automatic applyStimulus(input logic [3:0] off, input logic [31:0] d);
        en = 1'b1;
        write_enable = 3'b111;
        addr = {20'h0, off};
        data_in = d;
        @(posedge clk);
        #1;
        en = 1'b0;
        write_enable = 3'b000;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
        en = 1'b1;
        write_enable = 3'b000;
        addr = {20'h0, off};
        #1;
        d = data_out;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int div, input bit contig);
        frame_t f;
        f.data = b;
        f.div = div;
        f.contig = contig;
        sb.push_back(f);
        applyStimulus(OFF_TXDATA, {24'h0, b});
    endtask

    task automatic read_check(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(off, d);
        checkOutput(name, d, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && irq === 1'b1) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_timeout", 32'(n < budget), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: a low sample while idle starts a frame. Every sample of the
    // frame must match start/data/stop at exactly div samples per bit.
    initial begin
        frame_t     e;
        logic [9:0] expb;
        logic [9:0] got;
        int         errs;
        int         k;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                idle_cycles = 0;
            end else if (uart_txd === 1'b1) begin
                idle_cycles++;
            end else if (sb.size() == 0) begin
                checkOutput("unexpected_start", {31'h0, uart_txd}, 32'd1);
                k = 0;
                while (uart_txd !== 1'b1 && k < 2000) begin
                    @(negedge clk);
                    k++;
                end
                idle_cycles = 0;
            end else begin
                e = sb.pop_front();
                if (e.contig) begin
                    checkOutput("frame_gap", idle_cycles, 32'd0);
                end
                expb = {1'b1, e.data, 1'b0};
                got = '0;
                errs = 0;
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < e.div; j++) begin
                        if (i != 0 || j != 0) begin
                            @(negedge clk);
                        end
                        if (uart_txd !== expb[i]) begin
                            errs++;
                        end
                        if (j == e.div / 2) begin
                            got[i] = uart_txd;
                        end
                    end
                end
                checkOutput("frame_bits", {22'h0, got}, {22'h0, expb});
                checkOutput("frame_timing", errs, 32'd0);
                idle_cycles = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int lows;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_txd", {31'h0, uart_txd}, 32'd1);
        checkOutput("reset_irq", {31'h0, irq}, 32'd1);
        read_check("reset_status", OFF_STATUS, 32'h2);
        read_check("reset_div", OFF_DIV, 32'd104);
        read_check("txdata_read", OFF_TXDATA, 32'h0);
        mon_en = 1'b1;

        // Single 0x55 frame at div=4, one-cycle start latency.
        $display("[TB] single frame");
        applyStimulus(OFF_DIV, 32'd4);
        send(8'h55, 4, 1'b0);
        checkOutput("latency_pre", {31'h0, uart_txd}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("latency_start", {31'h0, uart_txd}, 32'd0);
        wait_idle(200);
        read_check("t1_status", OFF_STATUS, 32'h2);
        checkOutput("t1_irq", {31'h0, irq}, 32'd1);

        // Three back-to-back frames at div=2.
        $display("[TB] back-to-back frames");
        applyStimulus(OFF_DIV, 32'd2);
        send(8'h41, 2, 1'b0);
        send(8'h42, 2, 1'b1);
        send(8'h43, 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            repeat (9) @(posedge clk);
            #1;
            bus_read(OFF_STATUS, d);
            checkOutput("t2_busy", {31'h0, d[0]}, 32'd1);
        end
        wait_idle(300);

        // Overflow: one frame in flight, then DEPTH+2 pushes.
        $display("[TB] overflow");
        applyStimulus(OFF_DIV, 32'd4);
        send(8'hC3, 4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) begin
                send(8'(8'h10 + i), 4, 1'b1);
            end else begin
                applyStimulus(OFF_TXDATA, 32'(8'h10 + i));
            end
        end
        read_check("t3_status_full", OFF_STATUS, 32'hD);
        applyStimulus(OFF_STATUS, 32'h0);
        read_check("t3_status_clear", OFF_STATUS, 32'h5);
        wait_idle(17 * 40 + 200);
        read_check("t3_status_end", OFF_STATUS, 32'h2);

        // Divisor clamp and mid-frame divisor change.
        $display("[TB] divisor");
        applyStimulus(OFF_DIV, 32'd0);
        read_check("t4_div_clamp", OFF_DIV, 32'd2);
        applyStimulus(OFF_DIV, 32'd4);
        send(8'h3C, 4, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(OFF_DIV, 32'd10);
        send(8'hE7, 10, 1'b1);
        read_check("t4_div_read", OFF_DIV, 32'd10);
        wait_idle(400);

        // Reset during DATA aborts the frame.
        $display("[TB] reset mid-frame");
        mon_en = 1'b0;
        applyStimulus(OFF_TXDATA, 32'hA5);
        repeat (25) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_txd_async", {31'h0, uart_txd}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_check("t5_status", OFF_STATUS, 32'h2);
        read_check("t5_div", OFF_DIV, 32'd104);
        checkOutput("t5_irq", {31'h0, irq}, 32'd1);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) begin
                lows++;
            end
        end
        checkOutput("t5_line_idle", lows, 32'd0);

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
